// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types and constants
// Purpose: XLEN constant, fetch FSM state encoding and the buffered fetch entry.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of fetched {pc, instr} pairs
// Purpose: holds fetched instructions between memory response and decode.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - drop all entries (flush); takes priority over push/pop
//   push/wdata- write one entry at the tail
//   pop       - remove the head entry
//   head      - current head entry (undefined when empty)
//   empty     - no entries held
//   count     - number of entries held (0..DEPTH)
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch FSM with decode-side buffer
// Purpose: issues one outstanding instruction-memory read at a time, buffers
// responses and hands them to decode; supports redirect flush and flags
// misaligned fetch addresses.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   pc_in / pc_hold                - fetch address in; hold request to PC register
//   flush                          - discard buffered and in-flight fetches
//   imem_req/imem_addr/imem_gnt    - memory request handshake
//   imem_rvalid/imem_rdata         - memory read response
//   id_valid/id_ready/id_instr/id_pc - decode-side handshake and payload
//   misalign_err                   - sticky misaligned-address flag
module ifetch_unit #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_hold,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic            misalign_err
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] inflight_pc;
  logic            misalign_set;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [CW-1:0]   occupancy;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head_entry;
  logic            aligned;
  logic            has_room;

  assign aligned  = (pc_in[1:0] == 2'b00);
  // A request only issues from IDLE, where nothing is in flight, so checking
  // room here reserves the slot the response will land in.
  assign has_room = (occupancy < CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (imem_req && imem_gnt) state_next = WAIT;
      WAIT: begin
        if (imem_rvalid)  state_next = IDLE;
        else if (flush)   state_next = DRAIN;
      end
      // A flush while draining changes nothing: one response is still owed.
      DRAIN:   if (imem_rvalid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req     = 1'b0;
    push         = 1'b0;
    misalign_set = 1'b0;
    case (state)
      IDLE: begin
        imem_req     = !rst && !flush && !misalign_err && aligned && has_room;
        misalign_set = !flush && !aligned;
      end
      WAIT:    push = imem_rvalid && !flush;
      default: ;
    endcase
    pc_hold   = !(imem_req && imem_gnt);
    imem_addr = imem_req ? pc_in : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_pc  <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (imem_req && imem_gnt) inflight_pc <= pc_in;
      if (misalign_set)         misalign_err <= 1'b1;
    end
  end

  assign wr_entry = '{pc: inflight_pc, instr: imem_rdata};
  assign pop      = id_valid && id_ready && !flush;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .head  (head_entry),
    .empty (fifo_empty),
    .count (occupancy)
  );

  assign id_valid = !fifo_empty;
  assign id_instr = id_valid ? head_entry.instr : '0;
  assign id_pc    = id_valid ? head_entry.pc    : '0;

endmodule
